// File: rtl/core_mem_if_pkg.sv
// Shared types and widths for the per-core memory access controller.
package mem_pkg;

  localparam int unsigned ADR_W      = 16;
  localparam int unsigned DAT_W      = 16;
  localparam int unsigned LOCK_ADR_W = 10;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_STORE  = 2'd1,
    OP_LOCK   = 2'd2,
    OP_UNLOCK = 2'd3
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM_RD = 3'd1,
    ST_MEM_WR = 3'd2,
    ST_LOCK   = 3'd3,
    ST_UNLOCK = 3'd4
  } mem_if_state_t;

endpackage

// File: rtl/core_mem_if_if.sv
// Core-side command bus and arbiter-side request bus for core_mem_if.
interface core_req_if;
  import mem_pkg::*;

  logic             req_valid;
  mem_op_t          req_op;
  logic [ADR_W-1:0] req_adr;
  logic [DAT_W-1:0] req_wdat;
  logic             req_ready;
  logic             resp_valid;
  logic [DAT_W-1:0] resp_rdat;

  modport master (
    output req_valid, req_op, req_adr, req_wdat,
    input  req_ready, resp_valid, resp_rdat
  );

  modport slave (
    input  req_valid, req_op, req_adr, req_wdat,
    output req_ready, resp_valid, resp_rdat
  );
endinterface

interface arb_req_if;
  import mem_pkg::*;

  logic [ADR_W-1:0]      mem_read_adr;
  logic [ADR_W-1:0]      mem_write_adr;
  logic [DAT_W-1:0]      mem_write_dat;
  logic                  mem_read_request;
  logic                  mem_read;
  logic                  mem_write_request;
  logic                  mem_write;
  logic [DAT_W-1:0]      mem_dat;
  logic                  mem_ac;
  logic [LOCK_ADR_W-1:0] lock_adr;
  logic                  lock_en;
  logic                  unlock_en;
  logic                  lock_ac;

  modport master (
    output mem_read_adr, mem_write_adr, mem_write_dat,
           mem_read_request, mem_read, mem_write_request, mem_write,
           lock_adr, lock_en, unlock_en,
    input  mem_dat, mem_ac, lock_ac
  );

  modport slave (
    input  mem_read_adr, mem_write_adr, mem_write_dat,
           mem_read_request, mem_read, mem_write_request, mem_write,
           lock_adr, lock_en, unlock_en,
    output mem_dat, mem_ac, lock_ac
  );
endinterface

// File: rtl/core_mem_if_sat_counter.sv
// Saturating up-counter with synchronous clear; used for grant-wait statistics.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/core_mem_if.sv
// Per-core memory/lock request controller feeding one slice of the shared arbiter.
module core_mem_if
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  core_req_if.slave         core,
  arb_req_if.master         arb,
  output logic [WAIT_W-1:0] wait_cyc
);

  mem_if_state_t state_q, state_d;

  logic                  ready_q;
  logic                  rd_req_q,    rd_req_d;
  logic                  wr_req_q,    wr_req_d;
  logic                  lock_en_q,   lock_en_d;
  logic                  unlock_en_q, unlock_en_d;
  logic                  resp_vld_q,  resp_vld_d;
  logic [DAT_W-1:0]      rdat_q,      rdat_d;
  logic [ADR_W-1:0]      rd_adr_q,    rd_adr_d;
  logic [ADR_W-1:0]      wr_adr_q,    wr_adr_d;
  logic [DAT_W-1:0]      wr_dat_q,    wr_dat_d;
  logic [LOCK_ADR_W-1:0] lock_adr_q,  lock_adr_d;
  logic [WAIT_W-1:0]     wait_q,      wait_d;

  logic              cnt_clr;
  logic              cnt_inc;
  logic [WAIT_W-1:0] cnt;

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt)
  );

  // Next-state and next-output decode; strobes are re-asserted every busy cycle.
  always_comb begin
    state_d     = state_q;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;
    lock_en_d   = 1'b0;
    unlock_en_d = 1'b0;
    resp_vld_d  = 1'b0;
    rdat_d      = rdat_q;
    rd_adr_d    = rd_adr_q;
    wr_adr_d    = wr_adr_q;
    wr_dat_d    = wr_dat_q;
    lock_adr_d  = lock_adr_q;
    wait_d      = wait_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (core.req_valid) begin
          cnt_clr = 1'b1;
          case (core.req_op)
            OP_LOAD: begin
              state_d  = ST_MEM_RD;
              rd_req_d = 1'b1;
              rd_adr_d = core.req_adr;
            end
            OP_STORE: begin
              state_d  = ST_MEM_WR;
              wr_req_d = 1'b1;
              wr_adr_d = core.req_adr;
              wr_dat_d = core.req_wdat;
            end
            OP_LOCK: begin
              state_d    = ST_LOCK;
              lock_en_d  = 1'b1;
              lock_adr_d = core.req_adr[LOCK_ADR_W-1:0];
            end
            default: begin
              state_d     = ST_UNLOCK;
              unlock_en_d = 1'b1;
              lock_adr_d  = core.req_adr[LOCK_ADR_W-1:0];
            end
          endcase
        end
      end
      ST_MEM_RD: begin
        if (arb.mem_ac) begin
          state_d    = ST_IDLE;
          resp_vld_d = 1'b1;
          rdat_d     = arb.mem_dat;
          wait_d     = cnt;
        end else begin
          rd_req_d = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      ST_MEM_WR: begin
        if (arb.mem_ac) begin
          state_d    = ST_IDLE;
          resp_vld_d = 1'b1;
          wait_d     = cnt;
        end else begin
          wr_req_d = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      ST_LOCK: begin
        if (arb.lock_ac) begin
          state_d    = ST_IDLE;
          resp_vld_d = 1'b1;
          wait_d     = cnt;
        end else begin
          lock_en_d = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      ST_UNLOCK: begin
        if (arb.lock_ac) begin
          state_d    = ST_IDLE;
          resp_vld_d = 1'b1;
          wait_d     = cnt;
        end else begin
          unlock_en_d = 1'b1;
          cnt_inc     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      lock_en_q   <= 1'b0;
      unlock_en_q <= 1'b0;
      resp_vld_q  <= 1'b0;
      rdat_q      <= '0;
      rd_adr_q    <= '0;
      wr_adr_q    <= '0;
      wr_dat_q    <= '0;
      lock_adr_q  <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == ST_IDLE);
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      lock_en_q   <= lock_en_d;
      unlock_en_q <= unlock_en_d;
      resp_vld_q  <= resp_vld_d;
      rdat_q      <= rdat_d;
      rd_adr_q    <= rd_adr_d;
      wr_adr_q    <= wr_adr_d;
      wr_dat_q    <= wr_dat_d;
      lock_adr_q  <= lock_adr_d;
      wait_q      <= wait_d;
    end
  end

  assign core.req_ready       = ready_q;
  assign core.resp_valid      = resp_vld_q;
  assign core.resp_rdat       = rdat_q;
  assign arb.mem_read_adr     = rd_adr_q;
  assign arb.mem_write_adr    = wr_adr_q;
  assign arb.mem_write_dat    = wr_dat_q;
  assign arb.mem_read_request = rd_req_q;
  assign arb.mem_read         = rd_req_q;
  assign arb.mem_write_request = wr_req_q;
  assign arb.mem_write        = wr_req_q;
  assign arb.lock_adr         = lock_adr_q;
  assign arb.lock_en          = lock_en_q;
  assign arb.unlock_en        = unlock_en_q;
  assign wait_cyc             = wait_q;

endmodule

// File: doc/core_mem_if.md
# core_mem_if

Per-core memory access controller that sits directly upstream of the shared data-memory arbiter. It accepts one load, store, lock or unlock command at a time from the core pipeline and drives that core's slice of the arbiter request bus. It holds the request until the arbiter grants it, then returns load data and completion to the core. One instance exists per core; the top level concatenates instance outputs into the arbiter's `[C-1:0]` vectors and arrays.

## Interface
- `WAIT_W`, default 16: width of the saturating wait-cycle statistic counter.

- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core command valid.
- `req_op` in 2: `OP_LOAD`=0, `OP_STORE`=1, `OP_LOCK`=2, `OP_UNLOCK`=3.
- `req_adr` in 16: word address; lock ops use `req_adr[9:0]`.
- `req_wdat` in 16: store data.
- `req_ready` out 1: high iff state is IDLE.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdat` out 16: load data; holds its last value otherwise.
- `mem_read_adr` out 16: to arbiter read address.
- `mem_write_adr` out 16: to arbiter write address.
- `mem_write_dat` out 16: to arbiter write data.
- `mem_read_request` out 1: to arbiter.
- `mem_read` out 1: to arbiter.
- `mem_write_request` out 1: to arbiter.
- `mem_write` out 1: to arbiter.
- `mem_dat` in 16: shared arbiter read data.
- `mem_ac` in 1: this core's bit of the arbiter memory grant.
- `lock_adr` out 10: to arbiter.
- `lock_en` out 1: to arbiter.
- `unlock_en` out 1: to arbiter.
- `lock_ac` in 1: this core's bit of the arbiter lock grant.
- `wait_cyc` out WAIT_W: grant-wait cycles of the last completed command.

## Operation
- **States:** IDLE, MEM_RD, MEM_WR, LOCK, UNLOCK.
- **Accept:** a command is accepted on a posedge where `req_valid && req_ready`. Address and data are registered at that edge, and the FSM moves to the state selected by `req_op`.
- **MEM_RD:** `mem_read_request`=`mem_read`=1 and `mem_read_adr` is held. On a posedge with `mem_ac`=1:
  - capture `resp_rdat <= mem_dat`;
  - pulse `resp_valid`;
  - return to IDLE.
- **MEM_WR:** `mem_write_request`=`mem_write`=1, with address and data held. On `mem_ac`=1, pulse `resp_valid` and return to IDLE. The arbiter commits the write at the following negedge.
- **LOCK:** `lock_en`=1 with `lock_adr` held. The FSM waits for `lock_ac`, which implies the mutex was free. It stays in LOCK indefinitely while the mutex is held elsewhere.
- **UNLOCK:** `unlock_en`=1 until `lock_ac`, then complete.
- All arbiter-side outputs are registered and are 0 in IDLE. Address and data outputs hold their last value in IDLE.
- **Wait counter:** cleared on accept and incremented, saturating at `2^WAIT_W-1`, every busy cycle without a grant. It is copied to `wait_cyc` at completion.
- **Ignored inputs:**
  - `mem_ac` and `lock_ac` are ignored in IDLE.
  - `mem_ac` is ignored in the lock states.
  - `lock_ac` is ignored in the MEM states.

## Timing
- **Reset values:** state IDLE; all request, strobe and enable outputs 0; `resp_valid` 0; `resp_rdat`, all address/data outputs and `wait_cyc` 0.
- **Accept-to-bus latency:** with accept at edge N, arbiter outputs are asserted during cycle N+1.
- **Completion timing:** if the grant is high in cycle M (M ≥ N+1):
  - arbiter outputs are low in cycle M+1;
  - `resp_valid`=1 in cycle M+1;
  - `req_ready`=1 in cycle M+1.
- **Minimum turnaround:** 2 cycles. A back-to-back command may be accepted at the end of cycle M+1.
- **Grant sampling:** the grant is combinational in the arbiter and rotates on negedge. It is sampled only at posedge; a grant pulse that occurs between posedges is never missed, because requests are held steady.
- **Reset during a busy state:** forces IDLE and deasserts all outputs at the reset edge. No `resp_valid` is issued. A lock already granted in that cycle remains held in the arbiter; that is system-level reset's responsibility.
- **`req_valid` while busy:** ignored (`req_ready`=0); the core must hold it.

## Structure
- **Package `mem_pkg`:**
  - `mem_op_t` enum (2 bits);
  - `mem_if_state_t` enum;
  - `LOCK_ADR_W`=10;
  - `ADR_W`=16;
  - `DAT_W`=16.
- **Sub-module `sat_counter`:** parameterised width, with synchronous clear, increment and saturation. Used for `wait_cyc`.
- Everything else is a single FSM with registered outputs in `core_mem_if`.

## Test plan
- **Load, immediate grant:** LOAD adr=0x0010 with `mem_dat`=0xBEEF. `mem_ac` high in the first bus cycle gives `resp_valid` 2 cycles after accept, `resp_rdat`=0xBEEF, `wait_cyc`=0.
- **Store, delayed grant:** STORE adr=0x1234, dat=0x5A5A with `mem_ac` withheld 5 cycles. Address and data are held for 6 cycles and `wait_cyc`=5; strobes drop the cycle after the grant.
- **Contended lock:** LOCK adr=0x3FF with `lock_ac` low 20 cycles gives `lock_en` steady with `lock_adr`=0x3FF; completion follows the grant. A subsequent UNLOCK completes in 2 cycles on immediate `lock_ac`.
- **Stray and cross-type grants:** `mem_ac` pulses in IDLE and during LOCK give no state change and no `resp_valid`.
- **Reset mid-load:** reset asserted while in MEM_RD drives all outputs to 0 and `req_ready`=1 after the edge, with no response.
- **Saturation:** with WAIT_W=4 and a grant withheld 30 cycles, `wait_cyc`=15.
